// File: rtl/srlt_drv_pkg.sv
// srlt_pkg: shared types and constants for the SR latch write driver.
// Holds the FSM state encoding, default pulse/settle lengths and the
// helper that sizes the shared pulse/settle down-counter.
package srlt_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_PULSE  = 3'd1;
  localparam logic [2:0] ST_SETTLE = 3'd2;
  localparam logic [2:0] ST_CHECK  = 3'd3;
  localparam logic [2:0] ST_DONE   = 3'd4;

  typedef enum logic [2:0] {
    IDLE   = ST_IDLE,
    PULSE  = ST_PULSE,
    SETTLE = ST_SETTLE,
    CHECK  = ST_CHECK,
    DONE   = ST_DONE
  } state_t;

  localparam int DEF_PULSE_LEN  = 2;
  localparam int DEF_SETTLE_LEN = 2;

  // The counter only ever holds LEN-1, so $clog2 of the larger length is
  // enough bits; a length of 1 still needs a one-bit counter.
  function automatic int cnt_width(input int pulse_len, input int settle_len);
    int m;
    int w;
    m = (pulse_len > settle_len) ? pulse_len : settle_len;
    w = $clog2(m);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/srlt_drv_if.sv
// srlt_drv_if: request/completion bundle between a control FSM (master)
// and the SR latch write driver (slave).
interface srlt_drv_if;
  logic req_valid;
  logic req_val;
  logic req_ready;
  logic done;
  logic err;
  logic err_clr;

  modport master (
    output req_valid, req_val, err_clr,
    input  req_ready, done, err
  );

  modport slave (
    input  req_valid, req_val, err_clr,
    output req_ready, done, err
  );
endinterface

// File: rtl/srlt_drv_tmr.sv
// srlt_tmr: loadable down-counter with a zero flag. One instance is reused
// for both the pulse and the settle interval of the write driver.
module srlt_tmr #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] cnt;

  // Load wins over decrement; the count parks at zero instead of wrapping.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - W'(1);
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/srlt_drv.sv
// srlt_drv: write-side controller for one SR latch cell. Accepts a one-bit
// write, skips it when the latch already holds the value, otherwise drives
// one clean s or r pulse, waits for the latch to settle and completes.
// Optional feature macro: SRLT_DRV_VERIFY_EN adds the read-back CHECK state
// and the sticky err flag; without it err is tied low.
module srlt_drv
  import srlt_pkg::*;
#(
  parameter int PULSE_LEN  = DEF_PULSE_LEN,
  parameter int SETTLE_LEN = DEF_SETTLE_LEN
) (
  input  logic      clk,
  input  logic      rst_n,
  srlt_drv_if.slave bus,
  input  logic      q_in,
  output logic      s,
  output logic      r
);

  localparam int CW = cnt_width(PULSE_LEN, SETTLE_LEN);

  state_t          state;
  state_t          state_nxt;
  logic            val_q;
  logic            val_nxt;
  logic            tmr_load;
  logic [CW-1:0]   tmr_val;
  logic            tmr_dec;
  logic            tmr_zero;
`ifdef SRLT_DRV_VERIFY_EN
  logic            check_fail;
`endif

  srlt_tmr #(.W(CW)) u_tmr (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tmr_load),
    .load_val (tmr_val),
    .dec      (tmr_dec),
    .zero     (tmr_zero)
  );

  // Next-state, request capture and timer control for the write sequence.
  always_comb begin
    state_nxt = state;
    val_nxt   = val_q;
    tmr_load  = 1'b0;
    tmr_val   = '0;
    tmr_dec   = 1'b0;
`ifdef SRLT_DRV_VERIFY_EN
    check_fail = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (bus.req_valid) begin
          val_nxt = bus.req_val;
          if (q_in == bus.req_val) begin
            state_nxt = DONE;
          end else begin
            state_nxt = PULSE;
            tmr_load  = 1'b1;
            tmr_val   = CW'(PULSE_LEN - 1);
          end
        end
      end
      PULSE: begin
        if (tmr_zero) begin
          state_nxt = SETTLE;
          tmr_load  = 1'b1;
          tmr_val   = CW'(SETTLE_LEN - 1);
        end else begin
          tmr_dec = 1'b1;
        end
      end
      SETTLE: begin
        if (tmr_zero) begin
`ifdef SRLT_DRV_VERIFY_EN
          state_nxt = CHECK;
`else
          state_nxt = DONE;
`endif
        end else begin
          tmr_dec = 1'b1;
        end
      end
      CHECK: begin
`ifdef SRLT_DRV_VERIFY_EN
        check_fail = (q_in != val_q);
`endif
        state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register plus s/r registered from the next state so the pulse
  // lines up exactly with PULSE and can never assert both drives at once.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      val_q <= 1'b0;
      s     <= 1'b0;
      r     <= 1'b0;
    end else begin
      state <= state_nxt;
      val_q <= val_nxt;
      s     <= (state_nxt == PULSE) && val_nxt;
      r     <= (state_nxt == PULSE) && !val_nxt;
    end
  end

  assign bus.req_ready = (state == IDLE);
  assign bus.done      = (state == DONE);

`ifdef SRLT_DRV_VERIFY_EN
  // Sticky read-back error; a mismatch in the same cycle beats err_clr.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bus.err <= 1'b0;
    end else if (check_fail) begin
      bus.err <= 1'b1;
    end else if (bus.err_clr) begin
      bus.err <= 1'b0;
    end
  end
`else
  logic unused_err_clr;
  assign unused_err_clr = bus.err_clr;
  assign bus.err        = 1'b0;
`endif

endmodule

// File: tb/tb_srlt_drv.sv
// tb_srlt_drv: self-checking bench for srlt_drv with a behavioural SR latch
// model. Expectations come from the cycle arithmetic of the write sequence;
// SRLT_DRV_VERIFY_EN selects whether the CHECK cycle and err are expected.
module tb_srlt_drv;

  localparam int P = 2;
  localparam int S = 2;
`ifdef SRLT_DRV_VERIFY_EN
  localparam int VER = 1;
`else
  localparam int VER = 0;
`endif
  localparam int WLAT = P + S + 1 + VER;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic q_in;
  logic s;
  logic r;

  srlt_drv_if bus ();

  srlt_drv #(.PULSE_LEN(P), .SETTLE_LEN(S)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus),
    .q_in  (q_in),
    .s     (s),
    .r     (r)
  );

  always #5 clk = ~clk;

  // Latch model: force_en holds the cell at force_val (preset or stuck cell).
  logic latch_q   = 1'b0;
  logic force_en  = 1'b0;
  logic force_val = 1'b0;
  always @(posedge clk) begin
    if (force_en)  latch_q <= force_val;
    else if (s)    latch_q <= 1'b1;
    else if (r)    latch_q <= 1'b0;
  end
  assign q_in = latch_q;

  int compared   = 0;
  int mismatched = 0;
  logic model_err = 1'b0;

  logic [63:0] obs_s_v, obs_r_v, obs_done_v, obs_ready_v, obs_err_v;

  function automatic logic [63:0] bits_range(input int first, input int last);
    logic [63:0] v;
    v = '0;
    for (int i = first; i <= last; i++) v[i] = 1'b1;
    return v;
  endfunction

  task automatic set_latch(input logic v, input logic keep_stuck);
    force_en  = 1'b1;
    force_val = v;
    @(posedge clk); #1;
    force_en  = keep_stuck;
  endtask

  task automatic pulse_err_clr();
    bus.err_clr = 1'b1;
    @(posedge clk); #1;
    bus.err_clr = 1'b0;
  endtask

  // Issues one write and records outputs for cycles 1..ncyc after acceptance.
  task automatic capture(input logic v, input int ncyc, input int clr_cycle);
    int guard;
    guard = 0;
    while (!bus.req_ready && guard < 64) begin
      @(posedge clk); #1;
      guard++;
    end
    if (!bus.req_ready) begin
      compared++;
      mismatched++;
      $display("[TB] FAIL ready_timeout: got req_ready=%0b, want 1", bus.req_ready);
    end
    obs_s_v = '0; obs_r_v = '0; obs_done_v = '0; obs_ready_v = '0; obs_err_v = '0;
    bus.req_valid = 1'b1;
    bus.req_val   = v;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    for (int c = 1; c <= ncyc; c++) begin
      obs_s_v[c]     = s;
      obs_r_v[c]     = r;
      obs_done_v[c]  = bus.done;
      obs_ready_v[c] = bus.req_ready;
      obs_err_v[c]   = bus.err;
      bus.err_clr    = (c == clr_cycle);
      if (c < ncyc) begin
        @(posedge clk); #1;
      end
    end
    bus.err_clr = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    compared++; if (s !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_s: got %b, want 0", s); end
    compared++; if (r !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_r: got %b, want 0", r); end
    compared++; if (bus.done !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_done: got %b, want 0", bus.done); end
    compared++; if (bus.err !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_err: got %b, want 0", bus.err); end
    compared++; if (bus.req_ready !== 1'b1) begin mismatched++; $display("[TB] FAIL reset_ready: got %b, want 1", bus.req_ready); end
  endtask

  task automatic test_write_path();
    set_latch(1'b0, 1'b0);
    capture(1'b1, WLAT + 2, 0);
    compared++; if (obs_s_v !== bits_range(1, P)) begin mismatched++; $display("[TB] FAIL write_s: got %h, want %h", obs_s_v, bits_range(1, P)); end
    compared++; if (obs_r_v !== 64'h0) begin mismatched++; $display("[TB] FAIL write_r: got %h, want 0", obs_r_v); end
    compared++; if (obs_done_v !== bits_range(WLAT, WLAT)) begin mismatched++; $display("[TB] FAIL write_done: got %h, want %h", obs_done_v, bits_range(WLAT, WLAT)); end
    compared++; if (obs_err_v[WLAT] !== 1'b0) begin mismatched++; $display("[TB] FAIL write_err: got %b, want 0", obs_err_v[WLAT]); end
    compared++; if (obs_ready_v !== bits_range(WLAT + 1, WLAT + 2)) begin mismatched++; $display("[TB] FAIL write_ready: got %h, want %h", obs_ready_v, bits_range(WLAT + 1, WLAT + 2)); end
    compared++; if (latch_q !== 1'b1) begin mismatched++; $display("[TB] FAIL write_latch: got %b, want 1", latch_q); end
  endtask

  task automatic test_skip();
    set_latch(1'b1, 1'b0);
    capture(1'b1, 3, 0);
    compared++; if ((obs_s_v | obs_r_v) !== 64'h0) begin mismatched++; $display("[TB] FAIL skip_sr: got %h, want 0", obs_s_v | obs_r_v); end
    compared++; if (obs_done_v !== bits_range(1, 1)) begin mismatched++; $display("[TB] FAIL skip_done: got %h, want %h", obs_done_v, bits_range(1, 1)); end
    compared++; if (obs_ready_v !== bits_range(2, 3)) begin mismatched++; $display("[TB] FAIL skip_ready: got %h, want %h", obs_ready_v, bits_range(2, 3)); end
  endtask

  task automatic test_err();
    set_latch(1'b0, 1'b1);
    capture(1'b1, WLAT, 0);
    compared++; if (obs_done_v !== bits_range(WLAT, WLAT)) begin mismatched++; $display("[TB] FAIL stuck_done: got %h, want %h", obs_done_v, bits_range(WLAT, WLAT)); end
    compared++; if (obs_err_v[WLAT] !== 1'(VER)) begin mismatched++; $display("[TB] FAIL stuck_err: got %b, want %0d", obs_err_v[WLAT], VER); end
    pulse_err_clr();
    compared++; if (bus.err !== 1'b0) begin mismatched++; $display("[TB] FAIL err_clr: got %b, want 0", bus.err); end
    capture(1'b1, WLAT, P + S + 1);
    compared++; if (obs_err_v[WLAT] !== 1'(VER)) begin mismatched++; $display("[TB] FAIL err_set_wins: got %b, want %0d", obs_err_v[WLAT], VER); end
    pulse_err_clr();
    force_en = 1'b0;
  endtask

  task automatic test_reset_mid_pulse();
    bit done_seen;
    set_latch(1'b0, 1'b1);
    capture(1'b1, WLAT, 0);
    compared++; if (bus.err !== 1'(VER)) begin mismatched++; $display("[TB] FAIL pre_reset_err: got %b, want %0d", bus.err, VER); end
    set_latch(1'b0, 1'b0);
    bus.req_valid = 1'b1;
    bus.req_val   = 1'b1;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    compared++; if (s !== 1'b1) begin mismatched++; $display("[TB] FAIL mid_s_cycle1: got %b, want 1", s); end
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    compared++; if ({s, r} !== 2'b00) begin mismatched++; $display("[TB] FAIL mid_rst_sr: got %b, want 00", {s, r}); end
    compared++; if (bus.req_ready !== 1'b1) begin mismatched++; $display("[TB] FAIL mid_rst_ready: got %b, want 1", bus.req_ready); end
    compared++; if (bus.err !== 1'b0) begin mismatched++; $display("[TB] FAIL mid_rst_err: got %b, want 0", bus.err); end
    done_seen = bus.done;
    repeat (WLAT + 2) begin
      @(posedge clk); #1;
      if (bus.done) done_seen = 1'b1;
    end
    compared++; if (done_seen !== 1'b0) begin mismatched++; $display("[TB] FAIL mid_rst_no_done: got %b, want 0", done_seen); end
  endtask

  task automatic test_back_to_back();
    logic vals [3];
    int   acc [3];
    int   idx, cyc, dones, overlap, s_cycles, r_cycles;
    bit   taking;
    vals[0] = 1'b1; vals[1] = 1'b0; vals[2] = 1'b1;
    idx = 0; cyc = 0; dones = 0; overlap = 0; s_cycles = 0; r_cycles = 0;
    acc[0] = 0; acc[1] = 0; acc[2] = 0;
    set_latch(1'b0, 1'b0);
    bus.req_valid = 1'b1;
    bus.req_val   = vals[0];
    while (cyc < 200 && (idx < 3 || cyc < acc[2] + WLAT + 2)) begin
      if (s && r) overlap++;
      if (s) s_cycles++;
      if (r) r_cycles++;
      if (bus.done) dones++;
      taking = (idx < 3) && bus.req_ready && bus.req_valid;
      if (taking) acc[idx] = cyc;
      @(posedge clk); #1;
      cyc++;
      if (taking) begin
        idx++;
        if (idx < 3) bus.req_val = vals[idx];
        else         bus.req_valid = 1'b0;
      end
    end
    bus.req_valid = 1'b0;
    compared++; if (idx !== 3) begin mismatched++; $display("[TB] FAIL b2b_accepted: got %0d, want 3", idx); end
    compared++; if (acc[1] - acc[0] !== WLAT + 1) begin mismatched++; $display("[TB] FAIL b2b_spacing1: got %0d, want %0d", acc[1] - acc[0], WLAT + 1); end
    compared++; if (acc[2] - acc[1] !== WLAT + 1) begin mismatched++; $display("[TB] FAIL b2b_spacing2: got %0d, want %0d", acc[2] - acc[1], WLAT + 1); end
    compared++; if (dones !== 3) begin mismatched++; $display("[TB] FAIL b2b_dones: got %0d, want 3", dones); end
    compared++; if (overlap !== 0) begin mismatched++; $display("[TB] FAIL b2b_s_and_r: got %0d, want 0", overlap); end
    compared++; if (s_cycles !== 2 * P) begin mismatched++; $display("[TB] FAIL b2b_s_cycles: got %0d, want %0d", s_cycles, 2 * P); end
    compared++; if (r_cycles !== P) begin mismatched++; $display("[TB] FAIL b2b_r_cycles: got %0d, want %0d", r_cycles, P); end
    compared++; if (latch_q !== 1'b1) begin mismatched++; $display("[TB] FAIL b2b_latch: got %b, want 1", latch_q); end
  endtask

  task automatic test_random();
    logic v, p, stuck, skip, exp_q;
    int dcyc;
    logic [63:0] exp_s, exp_r;
    model_err = bus.err;
    for (int it = 0; it < 16; it++) begin
      v     = 1'($urandom % 2);
      p     = 1'($urandom % 2);
      stuck = ($urandom % 4) == 0;
      if (($urandom % 2) == 1) begin
        pulse_err_clr();
        model_err = 1'b0;
      end
      set_latch(p, stuck);
      skip  = (p == v);
      dcyc  = skip ? 1 : WLAT;
      exp_s = (!skip && v)  ? bits_range(1, P) : 64'h0;
      exp_r = (!skip && !v) ? bits_range(1, P) : 64'h0;
      exp_q = stuck ? p : v;
      if (VER == 1 && !skip && stuck) model_err = 1'b1;
      capture(v, WLAT + 1, 0);
      compared++; if (obs_s_v !== exp_s) begin mismatched++; $display("[TB] FAIL rnd%0d_s: got %h, want %h", it, obs_s_v, exp_s); end
      compared++; if (obs_r_v !== exp_r) begin mismatched++; $display("[TB] FAIL rnd%0d_r: got %h, want %h", it, obs_r_v, exp_r); end
      compared++; if (obs_done_v !== bits_range(dcyc, dcyc)) begin mismatched++; $display("[TB] FAIL rnd%0d_done: got %h, want %h", it, obs_done_v, bits_range(dcyc, dcyc)); end
      compared++; if (obs_err_v[WLAT + 1] !== model_err) begin mismatched++; $display("[TB] FAIL rnd%0d_err: got %b, want %b", it, obs_err_v[WLAT + 1], model_err); end
      compared++; if (latch_q !== exp_q) begin mismatched++; $display("[TB] FAIL rnd%0d_latch: got %b, want %b", it, latch_q, exp_q); end
      force_en = 1'b0;
    end
  endtask

  initial begin
    bus.req_valid = 1'b0;
    bus.req_val   = 1'b0;
    bus.err_clr   = 1'b0;
    $display("[TB] srlt_drv bench start, P=%0d S=%0d verify=%0d", P, S, VER);
    test_reset();
    test_write_path();
    test_skip();
    test_err();
    test_reset_mid_pulse();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got no finish, want finish before 500000");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
